// File: rtl/gcode_field_assembler.sv
`default_nettype none
// ============================================================================
// Module   : gcode_field_assembler
// Purpose  : Byte-level G-code line parser. Collects the ASCII digit strings
//            of the G, X, Y and Z words of one line. On LF it presents them
//            right-aligned and zero-padded, with a one-cycle completion pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_Clock50MHz   in   1               system clock, rising edge
//   i_Reset_n      in   1               asynchronous active-low reset
//   i_RxByte       in   8               received ASCII byte
//   i_RxValid      in   1               byte strobe (back-to-back legal)
//   o_GAscii       out  8*G_DIGITS      G digits, last digit in [7:0]
//   o_XAscii       out  8*AXIS_DIGITS   X digits
//   o_YAscii       out  8*AXIS_DIGITS   Y digits
//   o_ZAscii       out  8*AXIS_DIGITS   Z digits
//   o_FieldMask    out  4               {Z,Y,X,G} present in committed line
//   o_Overflow     out  1               a field exceeded its capacity
//   o_LineComplete out  1               one-cycle pulse, outputs valid
// ============================================================================
module gcode_field_assembler #(
   parameter int AXIS_DIGITS = 6,
   parameter int G_DIGITS    = 3
) (
   input  logic                     i_Clock50MHz,
   input  logic                     i_Reset_n,
   input  logic [7:0]               i_RxByte,
   input  logic                     i_RxValid,
   output logic [8*G_DIGITS-1:0]    o_GAscii,
   output logic [8*AXIS_DIGITS-1:0] o_XAscii,
   output logic [8*AXIS_DIGITS-1:0] o_YAscii,
   output logic [8*AXIS_DIGITS-1:0] o_ZAscii,
   output logic [3:0]               o_FieldMask,
   output logic                     o_Overflow,
   output logic                     o_LineComplete
);

   localparam int GW   = 8 * G_DIGITS;
   localparam int AW   = 8 * AXIS_DIGITS;
   localparam int MAXD = (AXIS_DIGITS > G_DIGITS) ? AXIS_DIGITS : G_DIGITS;
   localparam int CW   = $clog2(MAXD + 1);
   localparam logic [CW-1:0] G_CAP = CW'(G_DIGITS);
   localparam logic [CW-1:0] A_CAP = CW'(AXIS_DIGITS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FIELD   = 3'd1,
      S_FRAC    = 3'd2,
      S_SKIP    = 3'd3,
      S_COMMENT = 3'd4
   } state_t;

   // Field selector encoding: 0=G, 1=X, 2=Y, 3=Z (matches mask bit order)
   state_t            state_q, state_d;
   logic [GW-1:0]     wg_q, wg_d;
   logic [AW-1:0]     wx_q, wx_d;
   logic [AW-1:0]     wy_q, wy_d;
   logic [AW-1:0]     wz_q, wz_d;
   logic [3:0]        mask_q, mask_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        sel_q, sel_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [GW-1:0]     gascii_q;
   logic [AW-1:0]     xascii_q;
   logic [AW-1:0]     yascii_q;
   logic [AW-1:0]     zascii_q;
   logic [3:0]        fmask_q;
   logic              fovf_q;
   logic              done_q;

   logic              commit;

   // ------------------------------------------------------------------------
   // Byte classification. OR-ing 0x20 folds upper case onto lower case; the
   // folded value lands in 'a'..'z' only for genuine ASCII letters.
   // ------------------------------------------------------------------------
   logic [7:0] lc;
   logic       is_letter, is_gxyz, is_digit;
   logic       is_lf, is_cr, is_space, is_dot, is_semi;
   logic [1:0] letter_sel;
   logic [CW-1:0] cap;

   assign lc        = i_RxByte | 8'h20;
   assign is_letter = (lc >= 8'h61) && (lc <= 8'h7A);
   assign is_digit  = (i_RxByte >= 8'h30) && (i_RxByte <= 8'h39);
   assign is_lf     = (i_RxByte == 8'h0A);
   assign is_cr     = (i_RxByte == 8'h0D);
   assign is_space  = (i_RxByte == 8'h20);
   assign is_dot    = (i_RxByte == 8'h2E);
   assign is_semi   = (i_RxByte == 8'h3B);
   assign cap       = (sel_q == 2'd0) ? G_CAP : A_CAP;

   always_comb begin
      is_gxyz    = 1'b0;
      letter_sel = 2'd0;
      if (is_letter) begin
         case (lc)
            8'h67:   begin is_gxyz = 1'b1; letter_sel = 2'd0; end
            8'h78:   begin is_gxyz = 1'b1; letter_sel = 2'd1; end
            8'h79:   begin is_gxyz = 1'b1; letter_sel = 2'd2; end
            8'h7A:   begin is_gxyz = 1'b1; letter_sel = 2'd3; end
            default: begin is_gxyz = 1'b0; letter_sel = 2'd0; end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      wg_d    = wg_q;
      wx_d    = wx_q;
      wy_d    = wy_q;
      wz_d    = wz_q;
      mask_d  = mask_q;
      ovf_d   = ovf_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;

      if (i_RxValid) begin
         if (is_lf) begin
            // End of line from any state; an empty line commits nothing.
            commit  = |mask_q;
            wg_d    = '0;
            wx_d    = '0;
            wy_d    = '0;
            wz_d    = '0;
            mask_d  = '0;
            ovf_d   = 1'b0;
            sel_d   = 2'd0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end else if (is_cr) begin
            state_d = state_q;
         end else if (is_space) begin
            if ((state_q == S_FIELD) || (state_q == S_FRAC) || (state_q == S_SKIP))
               state_d = S_IDLE;
         end else begin
            case (state_q)
               S_IDLE, S_FIELD, S_FRAC: begin
                  if (is_gxyz) begin
                     // A repeated word on the same line restarts its field.
                     sel_d              = letter_sel;
                     cnt_d              = '0;
                     mask_d[letter_sel] = 1'b1;
                     case (letter_sel)
                        2'd0:    wg_d = '0;
                        2'd1:    wx_d = '0;
                        2'd2:    wy_d = '0;
                        default: wz_d = '0;
                     endcase
                     state_d = S_FIELD;
                  end else if (is_letter) begin
                     state_d = S_SKIP;
                  end else if (is_semi) begin
                     state_d = S_COMMENT;
                  end else if (state_q == S_IDLE) begin
                     state_d = S_IDLE;
                  end else if (is_digit) begin
                     // Fractional digits are dropped; integer digits shift in
                     // from the right until the field is full.
                     if (state_q == S_FIELD) begin
                        if (cnt_q < cap) begin
                           case (sel_q)
                              2'd0:    wg_d = {wg_q[GW-9:0], i_RxByte};
                              2'd1:    wx_d = {wx_q[AW-9:0], i_RxByte};
                              2'd2:    wy_d = {wy_q[AW-9:0], i_RxByte};
                              default: wz_d = {wz_q[AW-9:0], i_RxByte};
                           endcase
                           cnt_d = cnt_q + 1'b1;
                        end else begin
                           ovf_d = 1'b1;
                        end
                     end
                  end else if (is_dot && (state_q == S_FIELD)) begin
                     state_d = S_FRAC;
                  end else begin
                     state_d = S_SKIP;
                  end
               end
               S_SKIP: begin
                  if (is_semi)
                     state_d = S_COMMENT;
               end
               S_COMMENT: begin
                  state_d = S_COMMENT;
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_Clock50MHz or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q  <= S_IDLE;
         wg_q     <= '0;
         wx_q     <= '0;
         wy_q     <= '0;
         wz_q     <= '0;
         mask_q   <= '0;
         ovf_q    <= 1'b0;
         sel_q    <= 2'd0;
         cnt_q    <= '0;
         gascii_q <= '0;
         xascii_q <= '0;
         yascii_q <= '0;
         zascii_q <= '0;
         fmask_q  <= '0;
         fovf_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wg_q    <= wg_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
         wz_q    <= wz_d;
         mask_q  <= mask_d;
         ovf_q   <= ovf_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         done_q  <= commit;
         // Outputs capture the working set only on a non-empty LF.
         if (commit) begin
            gascii_q <= wg_q;
            xascii_q <= wx_q;
            yascii_q <= wy_q;
            zascii_q <= wz_q;
            fmask_q  <= mask_q;
            fovf_q   <= ovf_q;
         end
      end
   end

   assign o_GAscii       = gascii_q;
   assign o_XAscii       = xascii_q;
   assign o_YAscii       = yascii_q;
   assign o_ZAscii       = zascii_q;
   assign o_FieldMask    = fmask_q;
   assign o_Overflow     = fovf_q;
   assign o_LineComplete = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gcode_field_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcode_field_assembler
// Purpose  : Self-checking bench for gcode_field_assembler. Directed lines
//            followed by random lines, compared every cycle against a
//            line-level reference parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcode_field_assembler;

   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] SP = 8'h20;
   localparam logic [7:0] SC = 8'h3B;
   localparam logic [7:0] DT = 8'h2E;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [23:0] g_ascii;
   logic [47:0] x_ascii, y_ascii, z_ascii;
   logic [3:0]  fmask;
   logic        ovf;
   logic        done;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0]  line_q[$];
   logic [23:0] exp_g;
   logic [47:0] exp_x, exp_y, exp_z;
   logic [3:0]  exp_mask;
   logic        exp_ovf;
   logic        exp_pulse;
   int          pulse_cnt;

   gcode_field_assembler #(.AXIS_DIGITS(6), .G_DIGITS(3)) dut (
      .i_Clock50MHz   (clk),
      .i_Reset_n      (rst_n),
      .i_RxByte       (rx_byte),
      .i_RxValid      (rx_valid),
      .o_GAscii       (g_ascii),
      .o_XAscii       (x_ascii),
      .o_YAscii       (y_ascii),
      .o_ZAscii       (z_ascii),
      .o_FieldMask    (fmask),
      .o_Overflow     (ovf),
      .o_LineComplete (done)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic bit is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic bit is_letter(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
   endfunction

   // Field index of a G/X/Y/Z word letter, -1 otherwise.
   function automatic int field_of(input logic [7:0] c);
      case (c)
         8'h47, 8'h67: return 0;
         8'h58, 8'h78: return 1;
         8'h59, 8'h79: return 2;
         8'h5A, 8'h7A: return 3;
         default:      return -1;
      endcase
   endfunction

   // Parse one complete line (without its LF) word by word.
   task automatic model_line();
      logic [7:0]  b[$];
      logic [47:0] val[4];
      int          len[4];
      logic [3:0]  m;
      logic        o;
      int          n, i, f, capf;
      b = {};
      foreach (line_q[k]) if (line_q[k] != CR) b.push_back(line_q[k]);
      n = b.size();
      m = 4'b0;
      o = 1'b0;
      for (int k = 0; k < 4; k++) begin val[k] = '0; len[k] = 0; end
      i = 0;
      while (i < n) begin
         if (b[i] == SC) break;             // rest of line is a comment
         f = field_of(b[i]);
         if (f >= 0) begin
            capf   = (f == 0) ? 3 : 6;
            val[f] = '0;
            len[f] = 0;
            m[f]   = 1'b1;
            i++;
            while (i < n && is_digit(b[i])) begin
               if (len[f] < capf) begin
                  val[f] = (val[f] << 8) | 48'(b[i]);
                  len[f]++;
               end else o = 1'b1;
               i++;
            end
            if (i < n && b[i] == DT) begin
               i++;
               while (i < n && is_digit(b[i])) i++;
            end
            // Any unexpected terminator turns the rest of the word into junk.
            if (i < n && !is_letter(b[i]) && b[i] != SC && b[i] != SP)
               while (i < n && b[i] != SP && b[i] != SC) i++;
         end else if (is_letter(b[i])) begin
            while (i < n && b[i] != SP && b[i] != SC) i++;
         end else begin
            i++;
         end
      end
      if (m != 4'b0) begin
         exp_g     = val[0][23:0];
         exp_x     = val[1];
         exp_y     = val[2];
         exp_z     = val[3];
         exp_mask  = m;
         exp_ovf   = o;
         exp_pulse = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic check_all();
      chk("pulse", 48'(done),    48'(exp_pulse));
      chk("gascii", 48'(g_ascii), 48'(exp_g));
      chk("xascii", x_ascii,      exp_x);
      chk("yascii", y_ascii,      exp_y);
      chk("zascii", z_ascii,      exp_z);
      chk("mask",   48'(fmask),   48'(exp_mask));
      chk("ovf",    48'(ovf),     48'(exp_ovf));
   endtask

   task automatic step(input bit v, input logic [7:0] b);
      @(negedge clk);
      rx_valid = v;
      rx_byte  = b;
      @(posedge clk);
      #1;
      exp_pulse = 1'b0;
      if (v) begin
         if (b == LF) begin
            model_line();
            line_q = {};
         end else begin
            line_q.push_back(b);
         end
      end
      if (done === 1'b1) pulse_cnt++;
      rx_valid = 1'b0;
      check_all();
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         logic [7:0] c;
         c = s[i];
         step(1'b1, c);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      line_q    = {};
      exp_g     = '0;
      exp_x     = '0;
      exp_y     = '0;
      exp_z     = '0;
      exp_mask  = '0;
      exp_ovf   = 1'b0;
      exp_pulse = 1'b0;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      string alpha;
      int    len;
      alpha     = "GXYZgxyzMSf0123456789012345. ;#";
      rst_n     = 1'b0;
      rx_valid  = 1'b0;
      rx_byte   = 8'h00;
      pulse_cnt = 0;
      line_q    = {};
      exp_g = '0; exp_x = '0; exp_y = '0; exp_z = '0;
      exp_mask = '0; exp_ovf = 1'b0; exp_pulse = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      send_str("X123 Y45\n");
      chk("p1 pulse", 48'(done),  48'h1);
      chk("p1 x",     x_ascii,    48'h000000313233);
      chk("p1 y",     y_ascii,    48'h000000003435);
      chk("p1 z",     z_ascii,    48'h0);
      chk("p1 mask",  48'(fmask), 48'h6);
      chk("p1 ovf",   48'(ovf),   48'h0);
      step(1'b0, 8'h00);
      chk("p1 pulse off", 48'(done), 48'h0);

      send_str("g1 z12.75\015\n");
      chk("p2 g",    48'(g_ascii), 48'h000031);
      chk("p2 z",    z_ascii,      48'h3132);
      chk("p2 mask", 48'(fmask),   48'h9);

      send_str("X1234567\n");
      chk("p3 x",   x_ascii,    48'h313233343536);
      chk("p3 ovf", 48'(ovf),   48'h1);

      pulse_cnt = 0;
      send_str("; home\n");
      send_str("\n");
      step(1'b0, 8'h00);
      chk("p4 no pulse", 48'(pulse_cnt), 48'h0);
      chk("p4 hold x",   x_ascii,        48'h313233343536);
      send_str("Y9 X8\n");
      chk("p4 y", y_ascii, 48'h39);
      chk("p4 x", x_ascii, 48'h38);
      step(1'b0, 8'h00);
      chk("p4 one pulse", 48'(pulse_cnt), 48'h1);

      send_str("X55");
      do_reset();
      chk("p5 reset x", x_ascii, 48'h0);
      send_str("Y7\n");
      chk("p5 x",    x_ascii,    48'h0);
      chk("p5 y",    y_ascii,    48'h37);
      chk("p5 mask", 48'(fmask), 48'h4);

      send_str("M3 S100 X2\n");
      chk("p6 x",    x_ascii,    48'h32);
      chk("p6 mask", 48'(fmask), 48'h2);

      // Random lines, including idle cycles with junk on the byte bus.
      for (int l = 0; l < 60; l++) begin
         len = $urandom_range(0, 14);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
            if ($urandom_range(0, 19) == 0) step(1'b1, CR);
            else begin
               logic [7:0] c;
               c = alpha[$urandom_range(0, alpha.len() - 1)];
               step(1'b1, c);
            end
         end
         step(1'b1, LF);
      end
      step(1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
